// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, mid-bit sampling FSM and a
// valid/ready holding register carrying framing, parity and overrun status.
`timescale 1ns/1ps
module uart_rx_param #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic                 clk_50M,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);

  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_MID       = CNT_W'(HALF - 1);
  localparam logic [3:0]       IDX_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       IDX_STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP, WAIT_HIGH
  } state_t;

  state_t               state, state_nxt;
  logic                 rx_m, rx_s;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           idx;
  logic [DATA_BITS-1:0] shreg, shift_in;
  logic                 par_err_q, stop_err_q;
  logic                 tick, mid, commit, accept;

  // NOTE: reset is sampled on the clock edge, and every flop here updates with
  // non-blocking assignments so all registers see pre-edge values.
  // Synchroniser resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign tick = (cnt == CNT_LAST);
  assign mid  = (cnt == CNT_MID);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (!rx_s) state_nxt = START;
      START:     if (mid) state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (tick && idx == IDX_DATA_LAST) state_nxt = (PARITY != 0) ? PAR : STOP;
      PAR:       if (tick) state_nxt = STOP;
      STOP:      if (tick && idx == IDX_STOP_LAST) state_nxt = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    commit = (state == STOP) && tick && (idx == IDX_STOP_LAST);
    accept = rx_valid && rx_ready;
  end

  always_comb begin
    shift_in = (MSB_FIRST != 0) ? {shreg[DATA_BITS-2:0], rx_s}
                                : {rx_s, shreg[DATA_BITS-1:1]};
  end

  // Bit timing, data assembly and per-frame error accumulation.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt        <= '0;
          idx        <= '0;
          par_err_q  <= 1'b0;
          stop_err_q <= 1'b0;
        end
        START: cnt <= mid ? '0 : cnt + 1'b1;
        DATA: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            shreg <= shift_in;
            idx   <= (idx == IDX_DATA_LAST) ? 4'd0 : idx + 4'd1;
          end
        end
        PAR: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) par_err_q <= ((^shreg) ^ rx_s) != (PARITY == 2);
        end
        STOP: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            stop_err_q <= stop_err_q | ~rx_s;
            idx        <= idx + 4'd1;
          end
        end
        default: begin
          cnt <= '0;
          idx <= '0;
        end
      endcase
    end
  end

  // Holding register: a commit coinciding with an accept is a clean hand-over.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit) begin
      rx_data    <= shreg;
      frame_err  <= stop_err_q | ~rx_s;
      parity_err <= par_err_q;
      rx_valid   <= 1'b1;
      if (rx_valid && !accept) overrun <= 1'b1;
    end else if (accept) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: a default 8N1 LSB-first receiver and a
// 7-bit MSB-first even-parity receiver, driven with directed frames.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int CPB         = 434;
  localparam int HALF        = 217;
  localparam int CYCLE_LIMIT = 90_000;

  typedef struct {
    logic [8:0] data;
    logic       fe;
    logic       pe;
    logic       ovr;
  } exp_t;

  logic       clk_50M = 1'b0;
  logic       rst_n;
  logic       rx_a, rx_b, ready_a, ready_b;
  logic [7:0] rx_data_a;
  logic [6:0] rx_data_b;
  logic       valid_a, fe_a, pe_a, ovr_a, busy_a;
  logic       valid_b, fe_b, pe_b, ovr_b, busy_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #10 clk_50M = ~clk_50M;

  uart_rx_param dut_a (
    .clk_50M(clk_50M), .rst_n(rst_n), .rx(rx_a),
    .rx_data(rx_data_a), .rx_valid(valid_a), .rx_ready(ready_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun(ovr_a), .busy(busy_a)
  );

  uart_rx_param #(.DATA_BITS(7), .PARITY(1), .MSB_FIRST(1)) dut_b (
    .clk_50M(clk_50M), .rst_n(rst_n), .rx(rx_b),
    .rx_data(rx_data_b), .rx_valid(valid_b), .rx_ready(ready_b),
    .frame_err(fe_b), .parity_err(pe_b), .overrun(ovr_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitors: every transfer pops the oldest expected word and compares it.
  always @(negedge clk_50M) begin
    if (rst_n && valid_a && ready_a) begin
      if (q_a.size() == 0) begin
        total_cnt++;
        $display("FAIL a_unexpected_word: got data %0h, expected no word", rx_data_a);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check("a_data",    32'(rx_data_a), 32'(e.data));
        check("a_frame",   32'(fe_a),      32'(e.fe));
        check("a_parity",  32'(pe_a),      32'(e.pe));
        check("a_overrun", 32'(ovr_a),     32'(e.ovr));
      end
    end
  end

  always @(negedge clk_50M) begin
    if (rst_n && valid_b && ready_b) begin
      if (q_b.size() == 0) begin
        total_cnt++;
        $display("FAIL b_unexpected_word: got data %0h, expected no word", rx_data_b);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check("b_data",    32'(rx_data_b), 32'(e.data));
        check("b_frame",   32'(fe_b),      32'(e.fe));
        check("b_parity",  32'(pe_b),      32'(e.pe));
        check("b_overrun", 32'(ovr_b),     32'(e.ovr));
      end
    end
  end

  initial begin
    #(CYCLE_LIMIT * 20);
    $display("FAIL watchdog: got %0d cycles elapsed, expected completion", CYCLE_LIMIT);
    $fatal(1, "simulation time limit");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  task automatic bit_a(input logic v);
    rx_a = v;
    wait_cycles(CPB);
  endtask

  task automatic bit_b(input logic v);
    rx_b = v;
    wait_cycles(CPB);
  endtask

  // 8 data bits LSB-first; the line is left at the stop level afterwards.
  task automatic send_a(input logic [7:0] d, input logic stop_v);
    bit_a(1'b0);
    for (int i = 0; i < 8; i++) bit_a(d[i]);
    bit_a(stop_v);
  endtask

  // 7 data bits MSB-first, explicit parity bit, one stop bit.
  task automatic send_b(input logic [6:0] d, input logic par);
    bit_b(1'b0);
    for (int i = 6; i >= 0; i--) bit_b(d[i]);
    bit_b(par);
    bit_b(1'b1);
  endtask

  task automatic pulse_ready_a();
    ready_a = 1'b1;
    wait_cycles(1);
    ready_a = 1'b0;
  endtask

  task automatic pulse_ready_b();
    ready_b = 1'b1;
    wait_cycles(1);
    ready_b = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_data"},  32'(rx_data_a), 32'h0);
    check({tag, "_valid"}, 32'(valid_a),   32'h0);
    check({tag, "_frame"}, 32'(fe_a),      32'h0);
    check({tag, "_par"},   32'(pe_a),      32'h0);
    check({tag, "_ovr"},   32'(ovr_a),     32'h0);
    check({tag, "_busy"},  32'(busy_a),    32'h0);
  endtask

  initial begin
    int valid_cnt, idle_cnt, busy_seen, valid_seen;
    rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
    wait_cycles(3);
    check_reset_a("rst_a");
    check("rst_b_data",  32'(rx_data_b), 32'h0);
    check("rst_b_valid", 32'(valid_b),   32'h0);
    check("rst_b_ovr",   32'(ovr_b),     32'h0);
    check("rst_b_busy",  32'(busy_b),    32'h0);
    rst_n = 1'b1;
    wait_cycles(5);

    // 7E1 MSB-first: 0x5A has four ones, so the correct even parity bit is 0.
    q_b.push_back('{data: 9'h5A, fe: 1'b0, pe: 1'b0, ovr: 1'b0});
    send_b(7'h5A, 1'b0);
    wait_cycles(CPB);
    check("b_valid_held", 32'(valid_b), 32'h1);
    pulse_ready_b();
    q_b.push_back('{data: 9'h5A, fe: 1'b0, pe: 1'b1, ovr: 1'b0});
    send_b(7'h5A, 1'b1);
    wait_cycles(CPB);
    pulse_ready_b();
    check("b_valid_after_accept", 32'(valid_b), 32'h0);

    // 8N1 0xA5, held until accepted.
    q_a.push_back('{data: 9'hA5, fe: 1'b0, pe: 1'b0, ovr: 1'b0});
    send_a(8'hA5, 1'b1);
    wait_cycles(2 * CPB);
    check("a5_valid_held", 32'(valid_a), 32'h1);
    pulse_ready_a();
    check("a5_valid_after_accept", 32'(valid_a), 32'h0);

    // Break: stop bit low and line held low for 20 more bit times.
    q_a.push_back('{data: 9'h00, fe: 1'b1, pe: 1'b0, ovr: 1'b0});
    send_a(8'h00, 1'b0);
    check("brk_valid", 32'(valid_a), 32'h1);
    check("brk_busy",  32'(busy_a),  32'h1);
    pulse_ready_a();
    valid_cnt = 0; idle_cnt = 0;
    for (int k = 0; k < 20 * CPB; k++) begin
      wait_cycles(1);
      if (valid_a) valid_cnt++;
      if (!busy_a) idle_cnt++;
    end
    check("brk_extra_valid_cycles", 32'(valid_cnt), 32'h0);
    check("brk_idle_cycles_low",    32'(idle_cnt),  32'h0);
    rx_a = 1'b1;
    wait_cycles(5);
    check("brk_busy_released", 32'(busy_a), 32'h0);
    wait_cycles(CPB);

    // 100-cycle glitch: rejected, busy back low within HALF+3 cycles.
    busy_seen = 0; valid_seen = 0;
    rx_a = 1'b0;
    for (int k = 0; k < HALF + 3; k++) begin
      if (k == 100) rx_a = 1'b1;
      wait_cycles(1);
      if (busy_a)  busy_seen  = 1;
      if (valid_a) valid_seen = 1;
    end
    check("glitch_busy_seen", 32'(busy_seen),  32'h1);
    check("glitch_no_valid",  32'(valid_seen), 32'h0);
    check("glitch_busy_low",  32'(busy_a),     32'h0);
    wait_cycles(CPB);

    // Overrun: three back-to-back frames, none accepted until the last.
    q_a.push_back('{data: 9'h33, fe: 1'b0, pe: 1'b0, ovr: 1'b1});
    send_a(8'h11, 1'b1);
    send_a(8'h22, 1'b1);
    send_a(8'h33, 1'b1);
    wait_cycles(CPB);
    check("ovr_valid_held", 32'(valid_a), 32'h1);
    pulse_ready_a();
    check("ovr_valid_cleared", 32'(valid_a), 32'h0);
    check("ovr_flag_cleared",  32'(ovr_a),   32'h0);

    // Reset midway through data bit 4 of a frame, with an unaccepted word held.
    send_a(8'h5C, 1'b1);
    wait_cycles(CPB);
    check("pre_rst_valid", 32'(valid_a), 32'h1);
    bit_a(1'b0);
    bit_a(1'b0); bit_a(1'b0); bit_a(1'b1); bit_a(1'b1);
    rx_a = 1'b1;
    wait_cycles(CPB / 2);
    rst_n = 1'b0;
    wait_cycles(1);
    check_reset_a("midrst");
    rst_n = 1'b1;
    valid_cnt = 0;
    for (int k = 0; k < 12 * CPB; k++) begin
      wait_cycles(1);
      if (valid_a) valid_cnt++;
    end
    check("midrst_no_partial", 32'(valid_cnt), 32'h0);

    q_a.push_back('{data: 9'hC3, fe: 1'b0, pe: 1'b0, ovr: 1'b0});
    send_a(8'hC3, 1'b1);
    wait_cycles(CPB);
    pulse_ready_a();
    wait_cycles(4);

    check("a_queue_drained", 32'(q_a.size()), 32'h0);
    check("b_queue_drained", 32'(q_b.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver for the 50 MHz CPU/peripheral domain, succeeding the fixed 8-bit receiver. It synchronises the asynchronous `rx` line and samples mid-bit. Frame format (data width, bit order, parity, stop bits) is set by parameters. Received words are delivered through a valid/ready holding register with framing, parity and overrun status, for the UART-to-bus bridge or the instruction loader.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate. `CPB = CLK_FREQ/BAUD` (integer division; 434 at defaults). `HALF = CPB/2` (217).
- `DATA_BITS`, 8: data bits per frame. Legal range is 5..9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `MSB_FIRST`, 0: 0 = first data bit received is bit 0; 1 = first data bit received is bit `DATA_BITS-1`.

Ports:
- `clk_50M`, in, 1: the single clock. All logic is on the rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `rx`, in, 1: asynchronous serial input. Idle level is 1.
- `rx_data`, out, `DATA_BITS`: received word. Valid while `rx_valid`=1.
- `rx_valid`, out, 1: holding register is full.
- `rx_ready`, in, 1: consumer accepts the word. Transfer occurs when `rx_valid && rx_ready`.
- `frame_err`, out, 1: a stop bit of the held word sampled 0.
- `parity_err`, out, 1: parity mismatch on the held word. Always 0 when `PARITY`=0.
- `overrun`, out, 1: sticky flag; an unaccepted word was overwritten.
- `busy`, out, 1: receiver is in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser to produce `rx_s`. All decisions use `rx_s`.
- States: IDLE, START, DATA, PAR, STOP, WAIT_HIGH. One counter `cnt` (0..CPB-1) and one bit index `idx`.
- IDLE: when `rx_s`=0, go to START with `cnt`=0.
- START: count to `HALF-1`, then sample.
  - `rx_s`=0: go to DATA, `cnt`=0, `idx`=0.
  - `rx_s`=1: glitch; return to IDLE. No output change.
- DATA: sample each bit when `cnt`=CPB-1, then reset `cnt`.
  - Bits are placed per `MSB_FIRST`.
  - After `DATA_BITS` samples, go to PAR if `PARITY`≠0, else go to STOP.
- PAR: one bit period, then sample. Error if (XOR of data bits ^ parity bit) ≠ 0 for even parity, or ≠ 1 for odd parity.
- STOP: sample `STOP_BITS` bits at CPB-1 intervals. Any 0 sets the frame error.
- On the final stop sample, the frame commits. Next state:
  - IDLE if the last stop bit was 1.
  - WAIT_HIGH if it was 0 (break or line held low). WAIT_HIGH goes to IDLE only once `rx_s`=1, so a held-low line produces exactly one frame.
- Commit:
  - `rx_data`, `frame_err` and `parity_err` load together.
  - `rx_valid` is set to 1.
  - Errored frames are still delivered, with their flags set.
- Holding register behaviour:
  - Commit while `rx_valid`=1 and no accept in the same cycle: overwrite the word and set `overrun`=1.
  - Commit in the same cycle as an accept: the new word loads, `rx_valid` stays 1, and `overrun` is unchanged.
  - Accept with no commit: `rx_valid` goes to 0.
  - `overrun` clears on an accept that does not coincide with an overwrite.
- `rst_n`=0 at any time, including mid-frame, aborts the frame. No partial word is delivered.

## Timing
- Reset values (one clock edge with `rst_n`=0):
  - `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `busy`=0.
  - State is IDLE, `cnt`=0, `idx`=0.
  - Synchroniser flops are set to 1.
- Synchroniser latency is 2 cycles.
- Start falling edge to the first data sample is about `2+HALF+CPB` cycles.
- `rx_valid` rises 1 cycle after the final stop-bit sample. At defaults for 8N1, that is about 4123 cycles after the start edge.
- `busy` goes low in the same cycle `rx_valid` rises. A new start bit can be detected on the next cycle, so back-to-back frames need no idle gap.
- A start glitch shorter than `HALF` cycles is rejected. `busy` is high for `HALF` cycles, then returns to 0.

## Test plan
- Defaults (8N1, LSB-first): send 0xA5 at 434 cycles/bit → `rx_data`=0xA5, `frame_err`=0, `parity_err`=0, and `rx_valid` held high until `rx_ready` is pulsed.
- `MSB_FIRST`=1, `DATA_BITS`=7, `PARITY`=1: send 0x5A with a correct parity bit (0) → 0x5A, no errors. Repeat with parity bit 1 → 0x5A with `parity_err`=1.
- Stop bit driven 0, then line held low for 20 bit times → exactly one word (0x00), `frame_err`=1, `busy`=1 until `rx` returns high, and no further `rx_valid`.
- 100-cycle low pulse on an idle line → no `rx_valid`; `busy`=0 again within `HALF+3` cycles.
- Overrun: three back-to-back frames 0x11, 0x22, 0x33 with `rx_ready`=0 → `rx_data`=0x33, `overrun`=1. Pulse `rx_ready` once → `rx_valid`=0, `overrun`=0.
- `rst_n`=0 for 1 cycle midway through data bit 4 → all outputs at reset values. The next clean frame 0xC3 is received correctly.
